// File: rtl/itrx_aib_phy_dll_ctrl_if.sv
// Configuration/status bundle between the PHY register block and the DLL lock controller.
// The phase-detector input and the delay-line tap enables travel with it.
interface itrx_aib_phy_dll_ctrl_if #(
    parameter int unsigned DLYW = 10,
    parameter int unsigned NTAP = 64
);
    logic            dll_enable;
    logic            dll_lock_req;
    logic            dll_manual;
    logic [DLYW-1:0] dll_adjust;
    logic            pd_early;
    logic [DLYW-1:0] dll_code;
    logic [NTAP-1:0] dll_bk;
    logic            dll_lock;
    logic            dll_busy;

    modport master (
        output dll_enable, dll_lock_req, dll_manual, dll_adjust, pd_early,
        input  dll_code, dll_bk, dll_lock, dll_busy
    );

    modport slave (
        input  dll_enable, dll_lock_req, dll_manual, dll_adjust, pd_early,
        output dll_code, dll_bk, dll_lock, dll_busy
    );
endinterface

// File: rtl/itrx_aib_phy_dll_ctrl.sv
// DLL lock controller: forwards a manual delay code, or steps the code from a synchronized
// early/late detector until it has dithered LOCK_CNT times, then freezes it.
module itrx_aib_phy_dll_ctrl #(
    parameter int unsigned DLYW     = 10,
    parameter int unsigned NTAP     = 64,
    parameter int unsigned SETTLE   = 8,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned SYNC     = 2
) (
    input logic                          clk,
    input logic                          rst_n,
    itrx_aib_phy_dll_ctrl_if.slave       bus
);
    localparam int unsigned     CntW     = $clog2(SETTLE + 1);
    localparam logic [DLYW-1:0] CodeMax  = DLYW'(NTAP - 1);
    localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE - 1);
    localparam logic [3:0]      LockCnt  = 4'(LOCK_CNT);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StLocked} state_e;

    state_e          state_q, state_d;
    logic [DLYW-1:0] code_q, code_d;
    logic [SYNC-1:0] sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      rev_q, rev_d;
    logic            dir_vld_q, dir_vld_d;
    logic            dir_up_q, dir_up_d;
    logic            lock_q, lock_d;
    logic            busy_q, busy_d;

    logic            pde_s;
    logic            abort;
    logic            step_sat;
    logic [DLYW-1:0] code_step;
    logic [3:0]      rev_inc;
    logic [NTAP-1:0] bk;

    assign pde_s     = sync_q[SYNC-1];
    assign abort     = ~bus.dll_enable | ~bus.dll_lock_req;
    assign step_sat  = pde_s ? (code_q >= CodeMax) : (code_q == '0);
    assign code_step = pde_s ? code_q + DLYW'(1) : code_q - DLYW'(1);
    // A reversal only counts when a previous direction exists and differs.
    assign rev_inc   = (dir_vld_q && (dir_up_q != pde_s)) ? rev_q + 4'd1 : 4'd0;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        rev_d     = rev_q;
        dir_vld_d = dir_vld_q;
        dir_up_d  = dir_up_q;
        sync_d    = {sync_q[SYNC-2:0], bus.pd_early};

        if (bus.dll_manual) begin
            state_d = StIdle;
            code_d  = (bus.dll_adjust > CodeMax) ? CodeMax : bus.dll_adjust;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.dll_enable && bus.dll_lock_req) begin
                        state_d   = StSettle;
                        code_d    = '0;
                        rev_d     = '0;
                        dir_vld_d = 1'b0;
                        dir_up_d  = 1'b0;
                        cnt_d     = SettleLd;
                    end
                end
                StSettle: begin
                    if (abort) begin
                        state_d = StIdle;
                    end else if (cnt_q == '0) begin
                        state_d = StSample;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StSample: begin
                    if (abort) begin
                        state_d = StIdle;
                    end else if (step_sat) begin
                        state_d   = StSettle;
                        cnt_d     = SettleLd;
                        rev_d     = '0;
                        dir_vld_d = 1'b0;
                    end else begin
                        code_d    = code_step;
                        rev_d     = rev_inc;
                        dir_vld_d = 1'b1;
                        dir_up_d  = pde_s;
                        cnt_d     = SettleLd;
                        state_d   = (rev_inc == LockCnt) ? StLocked : StSettle;
                    end
                end
                StLocked: begin
                    if (abort) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        lock_d = (state_d == StLocked);
        busy_d = (state_d == StSettle) || (state_d == StSample);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            code_q    <= '0;
            sync_q    <= '0;
            cnt_q     <= '0;
            rev_q     <= '0;
            dir_vld_q <= 1'b0;
            dir_up_q  <= 1'b0;
            lock_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            rev_q     <= rev_d;
            dir_vld_q <= dir_vld_d;
            dir_up_q  <= dir_up_d;
            lock_q    <= lock_d;
            busy_q    <= busy_d;
        end
    end

    // Top tap never enables: code saturates at NTAP-1 so code > NTAP-1 cannot occur.
    always_comb begin
        bk = '0;
        for (int unsigned i = 0; i < NTAP - 1; i++) begin
            bk[i] = (code_q > DLYW'(i));
        end
    end

    assign bus.dll_code = code_q;
    assign bus.dll_bk   = bk;
    assign bus.dll_lock = lock_q;
    assign bus.dll_busy = busy_q;
endmodule

// File: tb/tb_itrx_aib_phy_dll_ctrl.sv
// Bench for the DLL lock controller: directed scenarios plus randomized episodes, all
// compared every cycle against a timer-based behavioural model of the acquisition.
module tb_itrx_aib_phy_dll_ctrl;
    localparam int unsigned DLYW     = 10;
    localparam int unsigned NTAP     = 64;
    localparam int unsigned SETTLE   = 8;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned SYNC     = 2;

    localparam int MIdle = 0;
    localparam int MAcq  = 1;
    localparam int MLock = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    itrx_aib_phy_dll_ctrl_if #(.DLYW(DLYW), .NTAP(NTAP)) bus ();

    itrx_aib_phy_dll_ctrl #(
        .DLYW     (DLYW),
        .NTAP     (NTAP),
        .SETTLE   (SETTLE),
        .LOCK_CNT (LOCK_CNT),
        .SYNC     (SYNC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode, code, cycles since acquisition start, reversal count, last dir.
    int m_mode, m_code, m_t, m_rev, m_last;
    bit pd_q[$];

    int det_mode = 0;  // 0: early below target, 1: stuck early, 2: stuck late, 3: noise
    int target   = 20;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] therm(input int c);
        therm = (64'd1 << c) - 64'd1;
    endfunction

    task automatic model_reset();
        m_mode = MIdle;
        m_code = 0;
        m_t    = 0;
        m_rev  = 0;
        m_last = 0;
        pd_q   = {};
        for (int i = 0; i < int'(SYNC); i++) pd_q.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit pde;
        int dir, nc;
        pde = pd_q.pop_front();
        pd_q.push_back(bus.pd_early);
        if (bus.dll_manual) begin
            m_mode = MIdle;
            m_code = (int'(bus.dll_adjust) > int'(NTAP) - 1) ? int'(NTAP) - 1
                                                            : int'(bus.dll_adjust);
        end else if (m_mode == MIdle) begin
            if (bus.dll_enable && bus.dll_lock_req) begin
                m_mode = MAcq;
                m_code = 0;
                m_t    = 0;
                m_rev  = 0;
                m_last = 0;
            end
        end else if (m_mode == MAcq) begin
            if (!bus.dll_enable || !bus.dll_lock_req) begin
                m_mode = MIdle;
            end else begin
                m_t++;
                if (m_t % (int'(SETTLE) + 1) == 0) begin
                    dir = pde ? 1 : -1;
                    nc  = m_code + dir;
                    if (nc < 0 || nc > int'(NTAP) - 1) begin
                        m_rev  = 0;
                        m_last = 0;
                    end else begin
                        m_rev  = (m_last != 0 && dir != m_last) ? m_rev + 1 : 0;
                        m_last = dir;
                        m_code = nc;
                        if (m_rev == int'(LOCK_CNT)) m_mode = MLock;
                    end
                end
            end
        end else begin
            if (!bus.dll_enable || !bus.dll_lock_req) m_mode = MIdle;
        end
    endtask

    task automatic check_outputs();
        check_val("code", 64'(bus.dll_code), 64'(m_code));
        check_val("bk", bus.dll_bk, therm(m_code));
        check_val("lock", 64'(bus.dll_lock), 64'(m_mode == MLock));
        check_val("busy", 64'(bus.dll_busy), 64'(m_mode == MAcq));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_outputs();
        case (det_mode)
            0:       bus.pd_early = (int'(bus.dll_code) < target);
            1:       bus.pd_early = 1'b1;
            2:       bus.pd_early = 1'b0;
            default: bus.pd_early = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_lock(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.dll_lock) break;
            tick();
        end
        check_val(tag, 64'(bus.dll_lock), 64'd1);
    endtask

    task automatic wait_code(input string tag, input int code, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(bus.dll_code) == code) break;
            tick();
        end
        check_val(tag, 64'(bus.dll_code), 64'(code));
    endtask

    initial begin
        int held, n, r;
        bus.dll_enable   = 1'b0;
        bus.dll_lock_req = 1'b0;
        bus.dll_manual   = 1'b0;
        bus.dll_adjust   = '0;
        bus.pd_early     = 1'b0;
        model_reset();

        #2 rst_n = 1'b0;
        #1;
        check_outputs();
        ticks(2);
        @(negedge clk) rst_n = 1'b1;
        ticks(2);

        // Manual mode, including clamp of an out-of-range code.
        bus.dll_manual = 1'b1;
        bus.dll_adjust = 10'd5;
        ticks(2);
        check_val("man5_code", 64'(bus.dll_code), 64'd5);
        check_val("man5_bk", bus.dll_bk, 64'h1f);
        bus.dll_adjust = 10'd200;
        tick();
        check_val("man200_code", 64'(bus.dll_code), 64'd63);
        check_val("man200_bk", bus.dll_bk, 64'h7fff_ffff_ffff_ffff);
        check_val("man_lock", 64'(bus.dll_lock), 64'd0);
        bus.dll_manual = 1'b0;
        tick();

        // Auto lock against a detector centred on code 20.
        det_mode = 0;
        target   = 20;
        bus.dll_enable   = 1'b1;
        bus.dll_lock_req = 1'b1;
        wait_lock("auto_lock", 400);
        check_val("auto_code_19_20", 64'(bus.dll_code == 10'd19 || bus.dll_code == 10'd20),
                  64'd1);
        ticks(20);
        check_val("auto_busy_after", 64'(bus.dll_busy), 64'd0);

        // Unlock via enable, then via manual while locked.
        held = int'(bus.dll_code);
        bus.dll_enable = 1'b0;
        tick();
        check_val("unlock_en_lock", 64'(bus.dll_lock), 64'd0);
        check_val("unlock_en_code", 64'(bus.dll_code), 64'(held));
        ticks(3);
        bus.dll_enable = 1'b1;
        wait_lock("relock", 400);
        bus.dll_adjust = bus.dll_code;
        held = int'(bus.dll_code);
        bus.dll_manual = 1'b1;
        tick();
        check_val("unlock_man_lock", 64'(bus.dll_lock), 64'd0);
        check_val("unlock_man_code", 64'(bus.dll_code), 64'(held));
        bus.dll_manual   = 1'b0;
        bus.dll_lock_req = 1'b0;
        tick();

        // Saturation high, then low.
        det_mode = 1;
        bus.dll_lock_req = 1'b1;
        wait_code("sat_hi_reach", 63, 800);
        ticks(40);
        check_val("sat_hi_code", 64'(bus.dll_code), 64'd63);
        check_val("sat_hi_lock", 64'(bus.dll_lock), 64'd0);
        bus.dll_lock_req = 1'b0;
        det_mode = 2;
        ticks(4);
        bus.dll_lock_req = 1'b1;
        ticks(100);
        check_val("sat_lo_code", 64'(bus.dll_code), 64'd0);
        check_val("sat_lo_lock", 64'(bus.dll_lock), 64'd0);

        // Abort in SETTLE at code 7, then re-request.
        bus.dll_lock_req = 1'b0;
        det_mode = 1;
        ticks(4);
        bus.dll_lock_req = 1'b1;
        wait_code("abort_reach7", 7, 200);
        ticks(2);
        bus.dll_lock_req = 1'b0;
        tick();
        check_val("abort_busy", 64'(bus.dll_busy), 64'd0);
        check_val("abort_code", 64'(bus.dll_code), 64'd7);
        ticks(5);
        bus.dll_lock_req = 1'b1;
        tick();
        check_val("rereq_code", 64'(bus.dll_code), 64'd0);
        check_val("rereq_busy", 64'(bus.dll_busy), 64'd1);

        // Randomized episodes with sporadic control toggles.
        for (int ep = 0; ep < 25; ep++) begin
            target   = int'($urandom_range(0, 63));
            det_mode = int'($urandom_range(0, 3));
            bus.dll_manual   = ($urandom_range(0, 4) == 0);
            bus.dll_adjust   = 10'($urandom_range(0, 1023));
            bus.dll_enable   = 1'b1;
            bus.dll_lock_req = 1'b1;
            n = int'($urandom_range(50, 400));
            for (int k = 0; k < n; k++) begin
                tick();
                r = int'($urandom_range(0, 99));
                if (r == 0) bus.dll_enable = ~bus.dll_enable;
                else if (r == 1) bus.dll_lock_req = ~bus.dll_lock_req;
                else if (r == 2) bus.dll_manual = ~bus.dll_manual;
                else if (r < 6) bus.dll_adjust = 10'($urandom_range(0, 1023));
            end
        end

        // Asynchronous reset in the middle of an acquisition.
        bus.dll_manual   = 1'b0;
        bus.dll_enable   = 1'b1;
        bus.dll_lock_req = 1'b0;
        det_mode = 1;
        ticks(2);
        bus.dll_lock_req = 1'b1;
        ticks(40);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_code", 64'(bus.dll_code), 64'd0);
        check_val("arst_bk", bus.dll_bk, 64'd0);
        check_val("arst_lock", 64'(bus.dll_lock), 64'd0);
        check_val("arst_busy", 64'(bus.dll_busy), 64'd0);
        model_reset();
        ticks(2);
        @(negedge clk) rst_n = 1'b1;
        ticks(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
